// File: rtl/spi_flash_responder.sv
// SPI NOR-flash responder (mode 0, single-bit I/O) used as the boot-flash model.
// Oversamples the SPI pins in the system clock domain and answers READ (0x03),
// RDID (0x9F) and RDSR (0x05); READ data comes from a synchronous memory port.
// Optional feature macro: SPI_FLASH_FAST_READ_EN adds FAST_READ (0x0B) with
// 8 dummy clocks between the address and the data phase.
module spi_flash_responder #(
    parameter int          ADDR_W     = 24,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic [7:0]        last_cmd
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, DATA, RDID, RDSR, IGNORE
    } state_t;

    state_t state, next_state;

    logic [1:0]  sck_sync, cs_sync, mosi_sync;
    logic        sck_prev, cs_prev;
    logic        sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
    logic [4:0]  bit_cnt;
    logic [22:0] shift_in;
    logic [7:0]  cmd_byte;
    logic [23:0] addr_full;
    logic [7:0]  data_buf;
    logic [7:0]  tx_sh;
    logic        cap;
    logic [1:0]  id_idx;

    // Two-flop synchronizers on the SPI pins plus previous-value flops for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_sync  <= 2'b00;
            cs_sync   <= 2'b00;
            mosi_sync <= 2'b00;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], spi_sck};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sck_prev  <= sck_sync[1];
            cs_prev   <= cs_sync[1];
        end
    end

    assign sck_rise  = sck_sync[1] & ~sck_prev;
    assign sck_fall  = ~sck_sync[1] & sck_prev;
    assign cs_rise   = cs_sync[1] & ~cs_prev;
    assign cs_fall   = ~cs_sync[1] & cs_prev;
    assign mosi_s    = mosi_sync[1];
    assign cmd_byte  = {shift_in[6:0], mosi_s};
    assign addr_full = {shift_in, mosi_s};

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode and busy; a chip-select rise overrides any sck edge
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            CMD, ADDR, DUMMY, DATA, RDID, RDSR: busy = 1'b1;
            default:                            busy = 1'b0;
        endcase
        if (cs_rise) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: if (cs_fall) next_state = CMD;
                CMD: begin
                    if (sck_rise && bit_cnt == 5'd7) begin
                        case (cmd_byte)
                            8'h03:   next_state = ADDR;
                            8'h9F:   next_state = RDID;
                            8'h05:   next_state = RDSR;
`ifdef SPI_FLASH_FAST_READ_EN
                            8'h0B:   next_state = ADDR;
`endif
                            default: next_state = IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    if (sck_rise && bit_cnt == 5'd23) begin
`ifdef SPI_FLASH_FAST_READ_EN
                        next_state = (last_cmd == 8'h0B) ? DUMMY : DATA;
`else
                        next_state = DATA;
`endif
                    end
                end
                DUMMY: if (sck_rise && bit_cnt == 5'd7) next_state = DATA;
                default: ;
            endcase
        end
    end

    // Shift, counter, memory-port and MISO datapath
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt     <= 5'd0;
            shift_in    <= 23'd0;
            data_buf    <= 8'd0;
            tx_sh       <= 8'd0;
            cap         <= 1'b0;
            id_idx      <= 2'd0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            last_cmd    <= 8'd0;
        end else begin
            mem_rd <= 1'b0;
            cap    <= mem_rd;
            if (cap) data_buf <= mem_rdata;

            if (cs_rise) begin
                // Abandon the transaction: partial bits and any pending fetch are dropped
                bit_cnt     <= 5'd0;
                shift_in    <= 23'd0;
                cap         <= 1'b0;
                spi_miso_oe <= 1'b0;
            end else begin
                case (state)
                    CMD: begin
                        if (sck_rise) begin
                            shift_in <= {shift_in[21:0], mosi_s};
                            if (bit_cnt == 5'd7) begin
                                bit_cnt  <= 5'd0;
                                last_cmd <= cmd_byte;
                                id_idx   <= 2'd0;
                                if (cmd_byte == 8'h9F) data_buf <= JEDEC_ID[23:16];
                                if (cmd_byte == 8'h05) data_buf <= STATUS_VAL;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (sck_rise) begin
                            shift_in <= {shift_in[21:0], mosi_s};
                            if (bit_cnt == 5'd23) begin
                                bit_cnt  <= 5'd0;
                                mem_addr <= addr_full[ADDR_W-1:0];
                                mem_rd   <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    DUMMY: begin
                        if (sck_rise) bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
                    end
                    DATA, RDID, RDSR: begin
                        if (sck_fall) begin
                            spi_miso_oe <= 1'b1;
                            bit_cnt     <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
                            if (bit_cnt == 5'd0) begin
                                // Byte boundary: start the next byte from the holding buffer
                                spi_miso <= data_buf[7];
                                tx_sh    <= {data_buf[6:0], 1'b0};
                            end else begin
                                spi_miso <= tx_sh[7];
                                tx_sh    <= {tx_sh[6:0], 1'b0};
                            end
                            // Prefetch the following byte while bit 0 goes out
                            if (state == DATA && bit_cnt == 5'd7) begin
                                mem_rd   <= 1'b1;
                                mem_addr <= mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                            end
                            if (state == RDID && bit_cnt == 5'd0) begin
                                case (id_idx)
                                    2'd0:    data_buf <= JEDEC_ID[15:8];
                                    2'd1:    data_buf <= JEDEC_ID[7:0];
                                    default: data_buf <= 8'h00;
                                endcase
                                if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: READ, RDID, RDSR, unknown opcode,
// address wrap, aborted READ, FAST_READ (per build macro) and mid-DATA reset.
module tb_spi_flash_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        spi_sck, spi_cs_n, spi_mosi;
    logic        spi_miso, spi_miso_oe, mem_rd, busy;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  last_cmd;

    int total = 0;
    int bad   = 0;
    int rd_cnt = 0;
    int b2b    = 0;
    logic rd_prev = 1'b0;
    logic [23:0] addr_q[$];
    logic [7:0]  rx;

    spi_flash_responder #(
        .ADDR_W(24), .JEDEC_ID(24'hEF4018), .STATUS_VAL(8'h5A)
    ) dut (
        .clock(clock), .reset(reset),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy), .last_cmd(last_cmd)
    );

    always #5 clock = ~clock;

    // Memory model: data = addr[7:0] ^ 0xA5, one cycle after the strobe
    always @(posedge clock) begin
        if (mem_rd) begin
            mem_rdata <= mem_addr[7:0] ^ 8'hA5;
            addr_q.push_back(mem_addr);
            rd_cnt++;
        end
        if (mem_rd && rd_prev) b2b++;
        rd_prev <= mem_rd;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input int i);
        if (i < addr_q.size()) return {8'h00, addr_q[i]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rxb);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            #80;
            spi_sck = 1'b1;
            rxb[i]  = spi_miso;
            #80;
            spi_sck = 1'b0;
        end
    endtask

    task automatic clk_bits(input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi = 1'b0;
            #80 spi_sck = 1'b1;
            #80 spi_sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        addr_q.delete();
        rd_cnt   = 0;
        spi_cs_n = 1'b0;
        #80;
    endtask

    task automatic cs_end();
        #80 spi_cs_n = 1'b1;
        #160;
    endtask

    task automatic send_read(input logic [7:0] op, input logic [23:0] a);
        xfer(op, rx);
        xfer(a[23:16], rx);
        xfer(a[15:8], rx);
        xfer(a[7:0], rx);
    endtask

    logic [7:0] exp_id [5] = '{8'hEF, 8'h40, 8'h18, 8'h00, 8'h00};
    logic [7:0] exp_rd [4] = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};

    initial begin
        reset = 1'b1; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        #12;
        chk("rst_miso_oe", spi_miso_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_last_cmd", last_cmd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_miso", spi_miso, 0);
        #10 reset = 1'b0;
        #100;

        // READ at 0x000010, four bytes
        cs_begin();
        send_read(8'h03, 24'h000010);
        chk("read_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            xfer(8'h00, rx);
            chk($sformatf("read_byte%0d", i), rx, exp_rd[i]);
        end
        chk("read_oe", spi_miso_oe, 1);
        cs_end();
        chk("read_rd_cnt", rd_cnt, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("read_addr%0d", i), q_at(i), 32'h10 + i);
        chk("read_last_cmd", last_cmd, 8'h03);
        chk("read_idle_busy", busy, 0);
        chk("read_idle_oe", spi_miso_oe, 0);

        // RDID, five bytes
        cs_begin();
        xfer(8'h9F, rx);
        for (int i = 0; i < 5; i++) begin
            xfer(8'h00, rx);
            chk($sformatf("rdid_byte%0d", i), rx, exp_id[i]);
        end
        cs_end();
        chk("rdid_no_rd", rd_cnt, 0);
        chk("rdid_last_cmd", last_cmd, 8'h9F);

        // RDSR, three bytes
        cs_begin();
        xfer(8'h05, rx);
        for (int i = 0; i < 3; i++) begin
            xfer(8'h00, rx);
            chk($sformatf("rdsr_byte%0d", i), rx, 8'h5A);
        end
        cs_end();
        chk("rdsr_last_cmd", last_cmd, 8'h05);

        // Unknown opcode 0x00
        cs_begin();
        xfer(8'h00, rx);
        xfer(8'hFF, rx);
        chk("ign_busy", busy, 0);
        chk("ign_oe", spi_miso_oe, 0);
        cs_end();
        chk("ign_last_cmd", last_cmd, 8'h00);
        chk("ign_no_rd", rd_cnt, 0);

        // Address wrap at the top of the space
        cs_begin();
        send_read(8'h03, 24'hFFFFFE);
        xfer(8'h00, rx); chk("wrap_byte0", rx, 8'h5B);
        xfer(8'h00, rx); chk("wrap_byte1", rx, 8'h5A);
        xfer(8'h00, rx); chk("wrap_byte2", rx, 8'hA5);
        cs_end();
        chk("wrap_addr0", q_at(0), 32'hFFFFFE);
        chk("wrap_addr1", q_at(1), 32'hFFFFFF);
        chk("wrap_addr2", q_at(2), 32'h000000);

        // READ aborted after 12 address bits, then a clean READ
        cs_begin();
        xfer(8'h03, rx);
        clk_bits(12);
        cs_end();
        chk("abort_no_rd", rd_cnt, 0);
        chk("abort_busy", busy, 0);
        cs_begin();
        send_read(8'h03, 24'h000020);
        xfer(8'h00, rx);
        chk("after_abort_byte", rx, 8'h85);
        cs_end();
        chk("after_abort_addr", q_at(0), 32'h20);

`ifdef SPI_FLASH_FAST_READ_EN
        // FAST_READ with 8 dummy clocks
        cs_begin();
        send_read(8'h0B, 24'h000001);
        for (int i = 0; i < 8; i++) begin
            spi_mosi = 1'b0;
            #80 spi_sck = 1'b1;
            chk($sformatf("fast_dummy_oe%0d", i), spi_miso_oe, 0);
            #80 spi_sck = 1'b0;
        end
        xfer(8'h00, rx);
        chk("fast_byte", rx, 8'hA4);
        cs_end();
        chk("fast_addr0", q_at(0), 32'h1);
        chk("fast_last_cmd", last_cmd, 8'h0B);
`else
        // 0x0B is unknown in this build
        cs_begin();
        xfer(8'h0B, rx);
        xfer(8'h00, rx);
        chk("nofast_busy", busy, 0);
        chk("nofast_oe", spi_miso_oe, 0);
        cs_end();
        chk("nofast_last_cmd", last_cmd, 8'h0B);
        chk("nofast_no_rd", rd_cnt, 0);
`endif

        // Reset in the middle of a DATA byte
        cs_begin();
        send_read(8'h03, 24'h000040);
        xfer(8'h00, rx);
        chk("mid_byte", rx, 8'hE5);
        clk_bits(4);
        chk("mid_oe_before", spi_miso_oe, 1);
        #4 reset = 1'b1;
        #1;
        chk("mid_rst_oe", spi_miso_oe, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mem_rd", mem_rd, 0);
        chk("mid_rst_last_cmd", last_cmd, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_miso", spi_miso, 0);
        #25 reset = 1'b0;
        spi_cs_n = 1'b1;
        #200;

        // Recovery after reset
        cs_begin();
        xfer(8'h05, rx);
        xfer(8'h00, rx);
        chk("recover_rdsr", rx, 8'h5A);
        cs_end();

        chk("no_back_to_back_rd", b2b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
